// File: rtl/fb_write_scheduler.sv
// Write-port scheduler for the double-buffered panel frame RAM: merges host pixel
// words and the fill engine into the back buffer and flips buffers only at scan end-of-frame.
module fb_write_scheduler #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  host_valid,
  input  logic [DATA_WIDTH-1:0] host_data,
  input  logic                  host_sof,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_colour,
  input  logic                  scan_frame_end,
  input  logic                  overrun_clr,
  output logic                  ram_we,
  output logic [ADDR_WIDTH:0]   ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  display_buf,
  output logic                  fill_busy,
  output logic                  flip_pending,
  output logic                  overrun
);

  typedef enum logic [1:0] {
    ACCEPT    = 2'd0,
    FILL      = 2'd1,
    WAIT_FLIP = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};

  state_t                  state;
  state_t                  state_nx;
  logic [ADDR_WIDTH-1:0]   wptr;
  logic [ADDR_WIDTH-1:0]   wptr_nx;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   colour;
  logic [DATA_WIDTH-1:0]   colour_nx;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    we;
  logic                    display_nx;
  logic                    drop;

  // Next-state, write selection and host-drop detection.
  always_comb begin
    state_nx   = state;
    wptr_nx    = wptr;
    colour_nx  = colour;
    display_nx = display_buf;
    we         = 1'b0;
    waddr      = wptr;
    wdata      = host_data;
    drop       = 1'b0;
    case (state)
      ACCEPT: begin
        if (host_valid) begin
          // host_sof resynchronises the stream to pixel 0 whatever wptr held
          we      = 1'b1;
          waddr   = host_sof ? ADDR_ZERO : wptr;
          wptr_nx = waddr + ADDR_ONE;
          if (waddr == ADDR_LAST) begin
            state_nx = WAIT_FLIP;
          end else begin
            state_nx = ACCEPT;
          end
        end else if (fill_start) begin
          colour_nx = fill_colour;
          wptr_nx   = ADDR_ZERO;
          state_nx  = FILL;
        end else begin
          state_nx = ACCEPT;
        end
      end
      FILL: begin
        we      = 1'b1;
        wdata   = colour;
        wptr_nx = wptr + ADDR_ONE;
        drop    = host_valid;
        if (wptr == ADDR_LAST) begin
          state_nx = WAIT_FLIP;
        end else begin
          state_nx = FILL;
        end
      end
      WAIT_FLIP: begin
        drop = host_valid;
        if (scan_frame_end) begin
          display_nx = ~display_buf;
          wptr_nx    = ADDR_ZERO;
          state_nx   = ACCEPT;
        end else begin
          state_nx = WAIT_FLIP;
        end
      end
      default: begin
        state_nx = ACCEPT;
        wptr_nx  = ADDR_ZERO;
      end
    endcase
  end

  // State, pointer and registered RAM/status outputs; reset abandons any fill or frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ACCEPT;
      wptr         <= ADDR_ZERO;
      colour       <= {DATA_WIDTH{1'b0}};
      display_buf  <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= {(ADDR_WIDTH+1){1'b0}};
      ram_data     <= {DATA_WIDTH{1'b0}};
      fill_busy    <= 1'b0;
      flip_pending <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nx;
      wptr         <= wptr_nx;
      colour       <= colour_nx;
      display_buf  <= display_nx;
      ram_we       <= we;
      // back buffer is always the one not on display; never taken from a wptr carry
      ram_addr     <= {~display_buf, waddr};
      ram_data     <= wdata;
      fill_busy    <= (state_nx == FILL);
      flip_pending <= (state_nx == WAIT_FLIP);
      if (drop) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end else begin
        overrun <= overrun;
      end
    end
  end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Owns the write port of the double-buffered panel frame RAM.
- Arbitrates between two writers:
  - host pixel words arriving from the SPI receive path;
  - an on-chip fill engine that paints the whole back buffer a single colour.
- Sequences the buffer flip so it occurs only at the scan side's end-of-frame, preventing tearing.
- Sits between the SPI word receiver and the RAM write port; exports the displayed-buffer select to the scan controller.

Parameters:
- ADDR_WIDTH, 11, word address bits per buffer (2048 words = 64x32 panel, top/bottom halves packed).
- DATA_WIDTH, 16, pixel word width (RGB 4:4:4 in [15:4], [3:0] unused).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  reset, asynchronous, active-high.
- host_valid  input  1  one-cycle strobe: host_data holds a pixel word (already synchronised to clk).
- host_data  input  DATA_WIDTH  host pixel word.
- host_sof  input  1  qualified by host_valid: this word is pixel 0 of a frame.
- fill_start  input  1  one-cycle request to fill back buffer.
- fill_colour  input  DATA_WIDTH  fill value, sampled on accepted fill_start.
- scan_frame_end  input  1  one-cycle pulse from scan controller after last row is shown.
- overrun_clr  input  1  clears overrun.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_WIDTH+1  RAM write address; MSB = back buffer = ~display_buf.
- ram_data  output  DATA_WIDTH  RAM write data.
- display_buf  output  1  buffer currently scanned out.
- fill_busy  output  1  high while fill in progress.
- flip_pending  output  1  back buffer complete, awaiting scan_frame_end.
- overrun  output  1  sticky: a host word was dropped.

Behaviour:
- Reset values:
  - all outputs 0, including display_buf = 0 (writes target buffer 1);
  - internal write pointer wptr = 0; state = ACCEPT.
- Reset mid-fill or mid-frame aborts immediately. No partial flip.
- Outputs ram_we/ram_addr/ram_data are registered: one cycle latency from an accepted host_valid, or from each fill step.
- State ACCEPT:
  - host_valid: write host_data at {~display_buf, wptr}.
  - host_sof with host_valid: the word is written at address 0 and wptr becomes 1, regardless of the old wptr. This gives host resync.
  - Otherwise wptr increments. If the word was written at address 2^ADDR_WIDTH-1, go to WAIT_FLIP.
  - fill_start with no host_valid: latch fill_colour, wptr = 0, go to FILL.
  - host_valid and fill_start in the same cycle: host wins; fill_start is dropped (fill_busy stays 0).
  - scan_frame_end ignored.
- State FILL:
  - fill_busy = 1; one write per cycle of the latched colour at {~display_buf, wptr}, wptr++.
  - Exactly 2^ADDR_WIDTH writes. After the last write (wptr wraps to 0), fill_busy drops and go to WAIT_FLIP.
  - host_valid: word dropped, overrun set. fill_start and scan_frame_end ignored.
- State WAIT_FLIP:
  - flip_pending = 1, no writes.
  - On scan_frame_end: display_buf toggles, wptr = 0, flip_pending clears next cycle, go to ACCEPT.
  - host_valid (including the same cycle as scan_frame_end): dropped, overrun set.
  - fill_start ignored.
- overrun:
  - set by any dropped host word; held until overrun_clr;
  - set and clear in the same cycle: set wins.
- wptr arithmetic is modulo 2^ADDR_WIDTH. The buffer-select bit is never derived from wptr carry, only from display_buf.

Test Plan:
- After reset, stream 2048 host words with data = index, first with host_sof.
  - Expect ram_addr 0x800..0xFFF with matching data, one cycle after each strobe.
  - flip_pending = 1 after the last word.
  - scan_frame_end pulse gives display_buf = 1; the next host word is written at 0x000.
- fill_start with fill_colour = 0xF000 in ACCEPT.
  - Expect fill_busy high exactly 2048 cycles, ram_we every one of those cycles, addresses 0x800..0xFFF all 0xF000.
  - Then flip_pending = 1 until scan_frame_end.
- host_valid and fill_start asserted in the same cycle.
  - Expect a single host write at 0x800; fill_busy never rises; state stays ACCEPT.
- host_valid during FILL and during WAIT_FLIP.
  - Expect no extra ram_we and overrun = 1, sticky until overrun_clr.
  - overrun_clr and a dropped word in the same cycle leave overrun = 1.
- Send 100 host words, then host_valid+host_sof with data 0xABC0.
  - Expect the write at 0x800; the following word goes to 0x801.
- Assert reset at fill step 500, then release.
  - Expect ram_we low at once, display_buf = 0, fill_busy = 0, flip_pending = 0.
  - A following host word is written at 0x800.
